bank_isu_credit_arb: RTL and testbench

- Credit-based round-robin arbiter between the ISU issue-queue channel slices (ch0..ch2) and the single ISU->SC issue port.
- Tracks one downstream xbar credit counter per channel. Grants a channel only when that channel holds at least one credit.
- Holds the grant stable under SC backpressure. Returned xbar credits replenish the counters.

---
 rtl/bank_isu_credit_arb.sv | 123 ++++++++++++
 tb/tb_bank_isu_credit_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bank_isu_credit_arb.sv
// Credit-gated round-robin arbiter from three ISU issue-queue channels onto the
// single ISU->SC issue port, with per-channel xbar credit counters.
module bank_isu_credit_arb #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MAX_CREDIT = 4,
  parameter int unsigned CRED_W     = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2:0]          req_valid_i,
  output logic [2:0]          req_ready_o,
  input  logic [3*DATA_W-1:0] req_data_i,
  output logic                isu_sc_valid_o,
  input  logic                isu_sc_ready_i,
  output logic [1:0]          isu_sc_channel_id_o,
  output logic [DATA_W-1:0]   isu_sc_data_o,
  input  logic [2:0]          xbar_isu_ch0_credit_i,
  input  logic [2:0]          xbar_isu_ch1_credit_i,
  input  logic [2:0]          xbar_isu_ch2_credit_i,
  output logic [2:0]          credit_avail_o,
  output logic                credit_ovf_o
);

  // One spare bit over the wider of counter/return so consume+return never wraps.
  localparam int unsigned SUM_W = ((CRED_W > 3) ? CRED_W : 3) + 1;

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t              state;
  logic [1:0]          lock_ch;
  logic [1:0]          rr_ptr;
  logic [CRED_W-1:0]   cnt [3];
  logic                ovf;

  logic [2:0]          elig;
  logic [2:0]          ret [3];
  logic [DATA_W-1:0]   data_arr [3];
  logic [SUM_W-1:0]    nxt [3];
  logic [1:0]          sel;
  logic [2:0]          idx;
  logic                found;
  logic                valid;
  logic                fire;

  always_comb begin
    ret[0] = xbar_isu_ch0_credit_i;
    ret[1] = xbar_isu_ch1_credit_i;
    ret[2] = xbar_isu_ch2_credit_i;
    elig   = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
      elig[k]     = req_valid_i[k] & (cnt[k] != '0);
    end
  end

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    if (state == ST_LOCK) begin
      sel   = lock_ch;
      found = 1'b1;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        idx = {1'b0, rr_ptr} + 3'(i);
        if (idx >= 3'd3) idx = idx - 3'd3;
        if (!found && elig[idx[1:0]]) begin
          sel   = idx[1:0];
          found = 1'b1;
        end
      end
    end
  end

  assign valid = found & ~rst_i;
  assign fire  = valid & isu_sc_ready_i;

  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      nxt[k] = SUM_W'(cnt[k]) - SUM_W'(fire && (sel == 2'(k))) + SUM_W'(ret[k]);
    end
  end

  assign isu_sc_valid_o      = valid;
  assign isu_sc_channel_id_o = valid ? sel : '0;
  assign isu_sc_data_o       = valid ? data_arr[sel] : '0;
  assign req_ready_o         = fire ? (3'b001 << sel) : '0;
  assign credit_ovf_o        = ovf & ~rst_i;

  always_comb begin
    credit_avail_o = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      credit_avail_o[k] = rst_i | (cnt[k] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_ARB;
      lock_ch <= '0;
      rr_ptr  <= '0;
      ovf     <= 1'b0;
      for (int unsigned k = 0; k < 3; k++) cnt[k] <= CRED_W'(MAX_CREDIT);
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (nxt[k] > SUM_W'(MAX_CREDIT)) begin
          cnt[k] <= CRED_W'(MAX_CREDIT);
          ovf    <= 1'b1;
        end else begin
          cnt[k] <= nxt[k][CRED_W-1:0];
        end
      end
      if (fire) begin
        state  <= ST_ARB;
        rr_ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      end else if (valid) begin
        state   <= ST_LOCK;
        lock_ch <= sel;
      end
    end
  end

endmodule

// File: tb/tb_bank_isu_credit_arb.sv
// Scoreboard bench for bank_isu_credit_arb: directed scenarios plus random
// traffic, checked against a queue-based behavioural model of the arbiter.
module tb_bank_isu_credit_arb;

  localparam int DW   = 32;
  localparam int MAXC = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [2:0]      req_valid_i;
  logic [2:0]      req_ready_o;
  logic [3*DW-1:0] req_data_i;
  logic            isu_sc_valid_o;
  logic            isu_sc_ready_i;
  logic [1:0]      isu_sc_channel_id_o;
  logic [DW-1:0]   isu_sc_data_o;
  logic [2:0]      c0, c1, c2;
  logic [2:0]      credit_avail_o;
  logic            credit_ovf_o;

  bank_isu_credit_arb #(.DATA_W(DW), .MAX_CREDIT(MAXC), .CRED_W(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .isu_sc_valid_o(isu_sc_valid_o), .isu_sc_ready_i(isu_sc_ready_i),
    .isu_sc_channel_id_o(isu_sc_channel_id_o), .isu_sc_data_o(isu_sc_data_o),
    .xbar_isu_ch0_credit_i(c0), .xbar_isu_ch1_credit_i(c1), .xbar_isu_ch2_credit_i(c2),
    .credit_avail_o(credit_avail_o), .credit_ovf_o(credit_ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit valid; int ch; logic [2:0] rdy; logic [2:0] avail; bit ovf; } cyc_t;
  typedef struct { int ch; logic [DW-1:0] data; } txn_t;

  cyc_t cyc_q[$];
  txn_t txn_q[$];

  int nchecks = 0;
  int nerr    = 0;

  // Reference model: credits as plain integers, pending-grant as a flag.
  int          mcnt [3];
  int          mptr;
  bit          mlock;
  int          mlock_ch;
  bit          movf;
  bit          pv [3];
  logic [DW-1:0] pd [3];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) mcnt[k] = MAXC;
    mptr = 0; mlock = 0; mlock_ch = 0; movf = 0;
  endtask

  // Called just after a rising edge; drives one cycle and predicts its outcome.
  task automatic step(input bit rst, input logic [2:0] mask, input int rdy_pct,
                      input int r0, input int r1, input int r2);
    cyc_t e;
    txn_t t;
    int   rr [3];
    bit   rdy, v, f;
    int   ch, n;
    rr[0] = r0; rr[1] = r1; rr[2] = r2;
    for (int k = 0; k < 3; k++) begin
      if (!pv[k] && mask[k]) begin
        pv[k] = 1;
        pd[k] = $urandom;
      end
    end
    rdy = ($urandom_range(0, 99) < rdy_pct);
    rst_i          = rst;
    isu_sc_ready_i = rdy;
    for (int k = 0; k < 3; k++) begin
      req_valid_i[k]         = pv[k];
      req_data_i[k*DW +: DW] = pd[k];
    end
    c0 = 3'(r0); c1 = 3'(r1); c2 = 3'(r2);

    v = 0; ch = 0;
    if (!rst) begin
      if (mlock) begin
        v = 1; ch = mlock_ch;
      end else begin
        for (int i = 0; i < 3; i++) begin
          int c;
          c = (mptr + i) % 3;
          if (!v && pv[c] && mcnt[c] > 0) begin v = 1; ch = c; end
        end
      end
    end
    f = v && rdy;
    e.valid = v;
    e.ch    = ch;
    e.rdy   = f ? 3'(1 << ch) : 3'b000;
    for (int k = 0; k < 3; k++) e.avail[k] = rst ? 1'b1 : (mcnt[k] > 0);
    e.ovf   = rst ? 1'b0 : movf;
    cyc_q.push_back(e);
    if (f) begin
      t.ch = ch; t.data = pd[ch];
      txn_q.push_back(t);
    end

    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        n = mcnt[k] - ((f && ch == k) ? 1 : 0) + rr[k];
        if (n > MAXC) begin n = MAXC; movf = 1; end
        mcnt[k] = n;
      end
      if (f) begin
        mlock = 0; mptr = (ch + 1) % 3; pv[ch] = 0;
      end else if (v) begin
        mlock = 1; mlock_ch = ch;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic phase_reset();
    for (int k = 0; k < 3; k++) pv[k] = 0;
    step(1, 3'b000, 0, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    cyc_t e;
    txn_t t;
    if (cyc_q.size() != 0) begin
      e = cyc_q.pop_front();
      check("isu_sc_valid", 64'(isu_sc_valid_o), 64'(e.valid));
      check("req_ready", 64'(req_ready_o), 64'(e.rdy));
      check("credit_avail", 64'(credit_avail_o), 64'(e.avail));
      check("credit_ovf", 64'(credit_ovf_o), 64'(e.ovf));
      check("channel_id", 64'(isu_sc_channel_id_o), e.valid ? 64'(e.ch) : 64'd0);
      if (!isu_sc_valid_o) check("idle_data", 64'(isu_sc_data_o), 64'd0);
      if (isu_sc_valid_o && isu_sc_ready_i) begin
        if (txn_q.size() == 0) begin
          check("unexpected_fire", 64'(isu_sc_channel_id_o), 64'hFF);
        end else begin
          t = txn_q.pop_front();
          check("fire_ch", 64'(isu_sc_channel_id_o), 64'(t.ch));
          check("fire_data", 64'(isu_sc_data_o), 64'(t.data));
        end
      end
    end
  end

  initial begin
    rst_i = 1; req_valid_i = '0; req_data_i = '0; isu_sc_ready_i = 0;
    c0 = '0; c1 = '0; c2 = '0;
    for (int k = 0; k < 3; k++) begin pv[k] = 0; pd[k] = '0; end
    model_reset();
    @(posedge clk); #1;

    // Full-rate round robin across all channels.
    phase_reset();
    repeat (6) step(0, 3'b111, 100, 0, 0, 0);

    // ch0 drains its credits, then one return reopens it.
    phase_reset();
    repeat (6) step(0, 3'b001, 100, 0, 0, 0);
    step(0, 3'b001, 100, 1, 0, 0);
    repeat (3) step(0, 3'b001, 100, 0, 0, 0);

    // Backpressure holds the grant on ch0 before ch1 gets its turn.
    phase_reset();
    repeat (3) step(0, 3'b011, 0, 0, 0, 0);
    repeat (3) step(0, 3'b011, 100, 0, 0, 0);

    // ch1 consume and return in the same cycle at cnt=1.
    phase_reset();
    repeat (3) step(0, 3'b010, 100, 0, 0, 0);
    step(0, 3'b010, 100, 0, 1, 0);
    repeat (3) step(0, 3'b010, 100, 0, 0, 0);

    // Overflow on a full counter is sticky; the counter itself saturates.
    phase_reset();
    step(0, 3'b000, 100, 0, 0, 2);
    repeat (6) step(0, 3'b100, 100, 0, 0, 0);

    // Reset while locked on ch2 drops the pending grant.
    phase_reset();
    repeat (2) step(0, 3'b011, 100, 0, 0, 0);
    repeat (2) step(0, 3'b100, 0, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0, 0);
    repeat (4) step(0, 3'b111, 100, 0, 0, 0);

    // Random traffic with in-range credit returns.
    phase_reset();
    repeat (400) begin
      int r [3];
      for (int k = 0; k < 3; k++)
        r[k] = ($urandom_range(0, 99) < 30) ? int'($urandom_range(0, MAXC - mcnt[k])) : 0;
      step(0, 3'($urandom_range(0, 7)), 60, r[0], r[1], r[2]);
    end
    step(1, 3'b000, 0, 0, 0, 0);

    check("txn_q_drained", 64'(txn_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
